// File: rtl/sync_word_fifo_if.sv
// sync_word_fifo_if -- handshake bundle for sync_word_fifo.
//
// Signals:
//   wr_en, wr_data        write request and the word to store
//   rd_en                 read request
//   rd_data, rd_valid     registered read word and its one-cycle strobe
//   full, empty, words    occupancy status
//   overflow, underflow   sticky error flags (only with SYNC_WORD_FIFO_ERR_FLAGS_EN)
//
// Modports: master = requester side, slave = FIFO side.
interface sync_word_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [COUNT_W-1:0] words;
`ifdef SYNC_WORD_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, rd_valid, full, empty, words, overflow, underflow);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, rd_valid, full, empty, words, overflow, underflow);
`else
  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, rd_valid, full, empty, words);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, rd_valid, full, empty, words);
`endif
endinterface

// File: rtl/sync_word_fifo.sv
// sync_word_fifo -- single-clock word FIFO with registered read data.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   sync_word_fifo_if.slave (write/read requests, read data, status)
//
// Parameters: DATA_W (word width), DEPTH (entries, power of two >= 2,
// <= 2**COUNT_W-1), COUNT_W (width of words). The interface instance must be
// built with the same DATA_W/COUNT_W.
//
// Optional feature: define SYNC_WORD_FIFO_ERR_FLAGS_EN to add the sticky
// overflow/underflow outputs on the interface.
module sync_word_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  sync_word_fifo_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic full, empty, wr_acc, rd_acc;

  // Status comes purely from the registered count, so there is no
  // combinational path from the request inputs to full/empty/words.
  assign full   = (words_q == DEPTH_CNT);
  assign empty  = (words_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    words_d    = words_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   words_d = words_q + COUNT_W'(1);
      2'b01:   words_d = words_q - COUNT_W'(1);
      default: words_d = words_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      words_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      words_q    <= words_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is deliberately not reset; entries are only read after a write.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.words    = words_q;

`ifdef SYNC_WORD_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Any write request while full counts, including the both-requested case
  // where the read is still accepted.
  always_comb begin
    overflow_d  = overflow_q  || (bus.wr_en && full);
    underflow_d = underflow_q || (bus.rd_en && empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_word_fifo.sv
// tb_sync_word_fifo -- directed bench for sync_word_fifo with a queue
// scoreboard and a reference occupancy model.
module tb_sync_word_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sync_word_fifo_if #(.DATA_W(8), .COUNT_W(4)) bus ();

  sync_word_fifo #(.DATA_W(8), .DEPTH(8), .COUNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_words = 0;
  bit ov_model = 1'b0;
  bit un_model = 1'b0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_words"},    32'(bus.words),    32'd0);
    check({tag, "_empty"},    32'(bus.empty),    32'd1);
    check({tag, "_full"},     32'(bus.full),     32'd0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
  endtask

  // Drive one cycle of requests, update the model, then check after the edge.
  task automatic cycle(input logic wr, input logic [7:0] wd, input logic rd, input string tag);
    bit acc_w, acc_r;
    logic [7:0] exp_d;
    acc_w = wr && (model_words < 8);
    acc_r = rd && (model_words > 0);
    if (wr && model_words == 8) ov_model = 1'b1;
    if (rd && model_words == 0) un_model = 1'b1;
    if (acc_w) sb.push_back(wd);
    model_words = model_words + int'(acc_w) - int'(acc_r);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    @(posedge clk);
    #1;
    check({tag, "_words"},    32'(bus.words),    32'(model_words));
    check({tag, "_full"},     32'(bus.full),     32'(model_words == 8));
    check({tag, "_empty"},    32'(bus.empty),    32'(model_words == 0));
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(acc_r));
    if (bus.rd_valid === 1'b1) begin
      check({tag, "_sb_has_word"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_d));
      end
    end
`ifdef SYNC_WORD_FIFO_ERR_FLAGS_EN
    check({tag, "_overflow"},  32'(bus.overflow),  32'(ov_model));
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(un_model));
`endif
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;

    // Reset, then idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, "idle");

    // Fill with 0x01..0x08, then a dropped write of 0xFF
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    cycle(1'b1, 8'hFF, 1'b0, "write_full");

    // Drain in order, then an extra read on empty
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, "drain");
    cycle(1'b0, 8'h00, 1'b1, "read_empty");

    // Occupancy 3, simultaneous read/write for 20 cycles across wraps
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, "pre3");
    for (int n = 0; n < 20; n++) cycle(1'b1, 8'(8'h10 + n), 1'b1, "steady3");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, "post3");

    // Full with both requested: only the read goes through
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, "refill");
    cycle(1'b1, 8'hEE, 1'b1, "full_both");
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, "drain7");

    // Empty with both requested: only the write goes through
    cycle(1'b1, 8'h55, 1'b1, "empty_both");
    cycle(1'b0, 8'h00, 1'b0, "empty_both_next");
    cycle(1'b0, 8'h00, 1'b1, "read_55");

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
`ifdef SYNC_WORD_FIFO_ERR_FLAGS_EN
    check("async_rst_overflow",  32'(bus.overflow),  32'd0);
    check("async_rst_underflow", 32'(bus.underflow), 32'd0);
`endif
    sb.delete();
    model_words = 0;
    ov_model = 1'b0;
    un_model = 1'b0;
    // Requests during reset must be ignored
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    bus.rd_en   = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("in_rst");
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst = 1'b0;
    cycle(1'b1, 8'hAA, 1'b0, "post_rst_wr");
    cycle(1'b0, 8'h00, 1'b1, "post_rst_rd");
    check("post_rst_rd_data_aa", 32'(bus.rd_data), 32'h0000_00AA);
    check("post_rst_empty",      32'(bus.empty),   32'd1);
    check("sb_drained",          32'(sb.size()),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_word_fifo.md
SYNC_WORD_FIFO -- requirements
Module: sync_word_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of stored words.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, at least 2, and at most 2**COUNT_W-1.
REQ-003 Parameter COUNT_W, default 4, width of the words output.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_en  in  1  write request, sampled each rising edge.
REQ-007 wr_data  in  DATA_W  word written when a write is accepted.
REQ-008 rd_en  in  1  read request, sampled each rising edge.
REQ-009 rd_data  out  DATA_W  registered read word.
REQ-010 rd_valid  out  1  high for exactly one cycle when rd_data holds a newly read word.
REQ-011 full  out  1  high when words == DEPTH.
REQ-012 empty  out  1  high when words == 0.
REQ-013 words  out  COUNT_W  current occupancy, 0..DEPTH.

Function
REQ-014 Write accepted = wr_en && !full; stores wr_data at the write pointer, which then increments modulo DEPTH.
REQ-015 Read accepted = rd_en && !empty; the entry at the read pointer is loaded into rd_data, and the read pointer increments modulo DEPTH.
REQ-016 Read latency: rd_data and rd_valid update on the same edge that accepts the read; data is visible in the following cycle.
REQ-017 rd_data holds its last value when no read is accepted; rd_valid is 0 in that cycle.
REQ-018 Occupancy: write only -> +1; read only -> -1; both or neither -> unchanged.
REQ-019 Full and both requested: only the read is accepted; words decrements by 1; wr_data is dropped.
REQ-020 Empty and both requested: only the write is accepted; words increments by 1; no read-through (rd_valid stays 0).
REQ-021 Write when full and read when empty are ignored; pointers, storage and words are unchanged.
REQ-022 full, empty and words are registered or derived only from registered state; no combinational path from wr_en or rd_en.
REQ-023 Pointer wrap from DEPTH-1 to 0 is seamless; FIFO order is preserved across any number of wraps.

Reset
REQ-024 rst asserted immediately forces these values: pointers 0, words 0, empty 1, full 0, rd_valid 0, rd_data 0.
REQ-025 Storage array contents are not reset; they are unobservable until rewritten.
REQ-026 Reset asserted mid-operation discards all stored words; the first accepted write after release is the first word read.
REQ-027 Requests are ignored while rst is high, and accepted from the first rising edge after release.

Configuration
REQ-028 Macro SYNC_WORD_FIFO_ERR_FLAGS_EN, when defined, adds two outputs:
  - overflow  out  1  sets on a write requested while full, or while full with both requested.
  - underflow  out  1  sets on a read requested while empty.
  - Both are sticky until rst, which clears them to 0.
REQ-029 When SYNC_WORD_FIFO_ERR_FLAGS_EN is undefined, the overflow and underflow ports and logic do not exist, and all other behaviour is identical.

Verification
REQ-030 Reset, then idle: empty=1, full=0, words=0, rd_valid=0.
REQ-031 Write 0x01..0x08 on 8 consecutive cycles:
  - words counts 1..8 and full=1 after the 8th edge.
  - A 9th write of 0xFF is dropped; words stays 8; overflow=1 if the macro is enabled.
REQ-032 From full, read 8 times:
  - rd_data = 0x01..0x08 in order, each with a one-cycle rd_valid pulse.
  - After the last read, empty=1 and words=0.
  - A 9th read gives rd_valid=0 and underflow=1 if the macro is enabled.
REQ-033 Occupancy 3 with wr_en=rd_en=1 for 20 cycles (wr_data=0x10+n):
  - words stays 3 throughout; pointers wrap at least twice.
  - Read order matches write order exactly.
REQ-034 Simultaneous-request edge cases:
  - Full with wr_en=rd_en=1: words becomes 7; the dropped word is never read.
  - Empty with both requested: words becomes 1, and rd_valid=0 in the next cycle.
REQ-035 Write 5 words, assert rst asynchronously between edges:
  - Outputs take reset values before the next edge.
  - After release, write 0xAA and read it back: rd_data=0xAA, empty=1.
